cnt16_match_ctrl: RTL and testbench

- Sequencing controller for the 16-bit cascaded counter/comparator datapath: start/stop, prescaled count enable, double-buffered compare value, one-shot or periodic match, and an interrupt handshake.
- Replaces free-running use of the counter's enable and compare inputs with a managed timer.
- Sits between the host control logic and the counter/compare datapath.
- Single clock domain.

---
 rtl/cnt16_match_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_cnt16_match_ctrl.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cnt16_match_ctrl.sv
// Sequencing controller for the cascaded 16-bit counter/comparator datapath.
// Provides start/stop control, a prescaled count enable, a double-buffered
// compare value, one-shot or periodic match, and a sticky IRQ/overrun pair.
module cnt16_match_ctrl #(
  parameter int W    = 16,
  parameter int PS_W = 4
) (
  input  logic            CK,
  input  logic            RN,
  input  logic            START,
  input  logic            STOP,
  input  logic            MODE,
  input  logic [PS_W-1:0] PS,
  input  logic            CMP_LD,
  input  logic [W-1:0]    CMP_IN,
  input  logic            ACK,
  output logic [W-1:0]    CNT,
  output logic            Z,
  output logic            IRQ,
  output logic            OVR,
  output logic            BUSY,
  output logic [1:0]      ST
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [W-1:0]      cnt_q, cnt_d;
  logic [PS_W-1:0]   pre_q, pre_d;
  logic [W-1:0]      act_q, act_d;
  logic [W-1:0]      shd_q, shd_d;
  logic              pend_q, pend_d;
  logic              mode_q, mode_d;
  logic [PS_W-1:0]   ps_q, ps_d;
  logic              z_q, z_d;
  logic              irq_q, irq_d;
  logic              ovr_q, ovr_d;
  logic              busy_q, busy_d;
  logic              tick_s;
  logic              match_s;

  // Next-state computation for the sequencer, compare buffers and interrupt flags.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pre_d   = pre_q;
    act_d   = act_q;
    shd_d   = shd_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    ps_d    = ps_q;
    irq_d   = irq_q;
    ovr_d   = ovr_q;
    match_s = 1'b0;
    tick_s  = (pre_q == ps_q);

    // Host writes always land in the shadow; pending marks an unconsumed value.
    if (CMP_LD) begin
      shd_d  = CMP_IN;
      pend_d = 1'b1;
    end else begin
      shd_d  = shd_q;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        // Outside RUN the active compare follows writes directly; a value left
        // pending from an interrupted run is consumed on restart.
        if (CMP_LD) begin
          act_d  = CMP_IN;
          pend_d = 1'b0;
        end else if (START && !STOP && pend_q) begin
          act_d  = shd_q;
          pend_d = 1'b0;
        end else begin
          act_d  = act_q;
        end

        if (STOP) begin
          state_d = ST_IDLE;
          cnt_d   = {W{1'b0}};
        end else if (START) begin
          state_d = ST_RUN;
          cnt_d   = {W{1'b0}};
          pre_d   = {PS_W{1'b0}};
          mode_d  = MODE;
          ps_d    = PS;
        end else begin
          state_d = state_q;
        end
      end

      ST_RUN: begin
        if (STOP) begin
          // Abort wins over a coincident match: no pulse, flags untouched.
          state_d = ST_IDLE;
          cnt_d   = {W{1'b0}};
          pre_d   = {PS_W{1'b0}};
        end else if (tick_s) begin
          pre_d = {PS_W{1'b0}};
          if (cnt_q == act_q) begin
            match_s = 1'b1;
            if (mode_q) begin
              cnt_d = {W{1'b0}};
              // A same-edge host write stays pending for the next period.
              if (pend_q) begin
                act_d  = shd_q;
                pend_d = CMP_LD;
              end else begin
                act_d  = act_q;
              end
            end else begin
              state_d = ST_DONE;
              cnt_d   = cnt_q;
            end
          end else begin
            cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
          end
        end else begin
          pre_d = pre_q + {{(PS_W-1){1'b0}}, 1'b1};
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = {W{1'b0}};
        pre_d   = {PS_W{1'b0}};
      end
    endcase

    // Match sets IRQ and wins over a same-edge ACK; overrun only when unacked.
    if (match_s) begin
      irq_d = 1'b1;
      ovr_d = ovr_q | (irq_q & ~ACK);
    end else if (ACK) begin
      irq_d = 1'b0;
      ovr_d = 1'b0;
    end else begin
      irq_d = irq_q;
      ovr_d = ovr_q;
    end

    z_d    = match_s;
    busy_d = (state_d == ST_RUN);
  end

  // State and registered outputs; asynchronous reset aborts any run at once.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= ST_IDLE;
      cnt_q   <= {W{1'b0}};
      pre_q   <= {PS_W{1'b0}};
      act_q   <= {W{1'b0}};
      shd_q   <= {W{1'b0}};
      pend_q  <= 1'b0;
      mode_q  <= 1'b0;
      ps_q    <= {PS_W{1'b0}};
      z_q     <= 1'b0;
      irq_q   <= 1'b0;
      ovr_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      act_q   <= act_d;
      shd_q   <= shd_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      ps_q    <= ps_d;
      z_q     <= z_d;
      irq_q   <= irq_d;
      ovr_q   <= ovr_d;
      busy_q  <= busy_d;
    end
  end

  assign CNT  = cnt_q;
  assign Z    = z_q;
  assign IRQ  = irq_q;
  assign OVR  = ovr_q;
  assign BUSY = busy_q;
  assign ST   = state_q;

endmodule

// File: tb/tb_cnt16_match_ctrl.sv
// Self-checking bench for cnt16_match_ctrl: directed scenarios plus random
// stimulus, all compared against an elapsed-time reference model.
module tb_cnt16_match_ctrl;

  localparam int W    = 16;
  localparam int PS_W = 4;

  logic            CK = 1'b0;
  logic            RN;
  logic            START, STOP, MODE, CMP_LD, ACK;
  logic [PS_W-1:0] PS;
  logic [W-1:0]    CMP_IN;
  logic [W-1:0]    CNT;
  logic            Z, IRQ, OVR, BUSY;
  logic [1:0]      ST;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: tracks clocks elapsed in the current period rather than
  // a prescaler; count value and match time follow from arithmetic on it.
  int m_st, m_cnt, m_e, m_ps, m_mode, m_act, m_shd, m_pend, m_z, m_irq, m_ovr;

  cnt16_match_ctrl #(.W(W), .PS_W(PS_W)) dut (
    .CK(CK), .RN(RN), .START(START), .STOP(STOP), .MODE(MODE), .PS(PS),
    .CMP_LD(CMP_LD), .CMP_IN(CMP_IN), .ACK(ACK),
    .CNT(CNT), .Z(Z), .IRQ(IRQ), .OVR(OVR), .BUSY(BUSY), .ST(ST)
  );

  always #5 CK = ~CK;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_st = 0; m_cnt = 0; m_e = 0; m_ps = 0; m_mode = 0; m_act = 0;
    m_shd = 0; m_pend = 0; m_z = 0; m_irq = 0; m_ovr = 0;
  endtask

  task automatic model_step();
    int n_st, n_cnt, n_e, n_ps, n_mode, n_act, n_shd, n_pend, match;
    n_st = m_st; n_cnt = m_cnt; n_e = m_e; n_ps = m_ps; n_mode = m_mode;
    n_act = m_act; n_shd = m_shd; n_pend = m_pend; match = 0;
    if (CMP_LD) begin n_shd = int'(CMP_IN); n_pend = 1; end
    if (m_st != 1) begin
      if (CMP_LD) begin
        n_act = int'(CMP_IN); n_pend = 0;
      end else if (START && !STOP && m_pend != 0) begin
        n_act = m_shd; n_pend = 0;
      end
      if (STOP) begin
        n_st = 0; n_cnt = 0;
      end else if (START) begin
        n_st = 1; n_cnt = 0; n_e = 0; n_ps = int'(PS); n_mode = int'(MODE);
      end
    end else if (STOP) begin
      n_st = 0; n_cnt = 0;
    end else begin
      n_e = m_e + 1;
      if (n_e == (m_act + 1) * (m_ps + 1)) begin
        match = 1;
        if (m_mode != 0) begin
          n_cnt = 0; n_e = 0;
          if (m_pend != 0) begin n_act = m_shd; n_pend = int'(CMP_LD); end
        end else begin
          n_st = 2; n_cnt = m_act;
        end
      end else begin
        n_cnt = n_e / (m_ps + 1);
      end
    end
    if (match != 0) begin
      if (m_irq != 0 && !ACK) m_ovr = 1;
      m_irq = 1;
    end else if (ACK) begin
      m_irq = 0; m_ovr = 0;
    end
    m_z = match;
    m_st = n_st; m_cnt = n_cnt; m_e = n_e; m_ps = n_ps; m_mode = n_mode;
    m_act = n_act; m_shd = n_shd; m_pend = n_pend;
  endtask

  task automatic check_all();
    check_val("cnt",  32'(CNT),  32'(m_cnt));
    check_val("z",    32'(Z),    32'(m_z));
    check_val("irq",  32'(IRQ),  32'(m_irq));
    check_val("ovr",  32'(OVR),  32'(m_ovr));
    check_val("busy", 32'(BUSY), (m_st == 1) ? 32'd1 : 32'd0);
    check_val("st",   32'(ST),   32'(m_st));
  endtask

  task automatic cyc(input logic st, input logic sp, input logic md, input int ps,
                     input logic ld, input int cin, input logic ak);
    START = st; STOP = sp; MODE = md; PS = PS_W'(ps);
    CMP_LD = ld; CMP_IN = W'(cin); ACK = ak;
    @(posedge CK);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
  endtask

  initial begin
    RN = 1'b0; START = 1'b0; STOP = 1'b0; MODE = 1'b0; PS = '0;
    CMP_LD = 1'b0; CMP_IN = '0; ACK = 1'b0;
    model_reset();
    #12;
    check_all();
    RN = 1'b1;

    // One-shot, CMP=3, PS=0
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, 3, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    idle(4);
    check_val("t1_done_st", 32'(ST), 32'd2);
    check_val("t1_done_cnt", 32'(CNT), 32'd3);
    check_val("t1_z", 32'(Z), 32'd1);
    idle(2);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    check_val("t1_ack_irq", 32'(IRQ), 32'd0);

    // Periodic, CMP=2, PS=1: two unacked matches produce overrun
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, 2, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1, 1'b0, 0, 1'b0);
    idle(12);
    check_val("t2_ovr", 32'(OVR), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    check_val("t2_ack_ovr", 32'(OVR), 32'd0);
    cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);

    // Periodic CMP=4 with a mid-period shadow load of 1
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, 4, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
    idle(2);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, 1, 1'b0);
    idle(2);
    check_val("t3_old_match", 32'(Z), 32'd1);
    idle(2);
    check_val("t3_new_match", 32'(Z), 32'd1);
    idle(6);
    cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1);

    // START+STOP in IDLE; STOP coincident with a match
    cyc(1'b1, 1'b1, 1'b1, 0, 1'b0, 0, 1'b0);
    check_val("t4_stay_idle", 32'(ST), 32'd0);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, 2, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
    idle(2);
    cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    check_val("t4_stop_z", 32'(Z), 32'd0);
    check_val("t4_stop_irq", 32'(IRQ), 32'd0);

    // ACK on the match edge; CMP=0 periodic
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, 1, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0, 1'b1);
    check_val("t5_ack_match_irq", 32'(IRQ), 32'd1);
    cyc(1'b0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, 0, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0);
    idle(6);

    // Asynchronous reset between edges while running
    cyc(1'b0, 1'b1, 1'b0, 0, 1'b1, 5, 1'b0);
    cyc(1'b1, 1'b0, 1'b1, 1, 1'b0, 0, 1'b0);
    idle(3);
    #3;
    RN = 1'b0;
    #1;
    model_reset();
    check_val("t6_cnt", 32'(CNT), 32'd0);
    check_val("t6_busy", 32'(BUSY), 32'd0);
    check_val("t6_irq", 32'(IRQ), 32'd0);
    check_all();
    #2;
    RN = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0, 1'b0);
    idle(1);
    check_val("t6_first_tick_z", 32'(Z), 32'd1);
    idle(1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom_range(0, 5) == 0), ($urandom_range(0, 39) == 0),
          1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
          ($urandom_range(0, 15) == 0), int'($urandom_range(0, 6)),
          ($urandom_range(0, 11) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
